// File: rtl/ddr_arb_pkg.sv
// ddr_arb_pkg: shared types and constants for the DDR burst arbiter.
package ddr_arb_pkg;

  // Default widths of the DDR user interface.
  localparam int DEF_DATA_WIDTH = 256;
  localparam int DEF_ADDR_WIDTH = 28;
  localparam int DEF_LEN_WIDTH  = 10;

  // Requester indices; the 2-bit value doubles as grant_id = {is_read, port}.
  localparam logic [1:0] WR0 = 2'd0;
  localparam logic [1:0] WR1 = 2'd1;
  localparam logic [1:0] RD0 = 2'd2;
  localparam logic [1:0] RD1 = 2'd3;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/ddr_burst_arbiter_if.sv
// ddr_burst_arbiter_if: burst command/data bundle between the arbiter
// (master) and the DDR burst controller (slave).
interface ddr_burst_arbiter_if import ddr_arb_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) ();

  localparam int BA = ADDR_WIDTH - 3;

  logic                  ddr_wr_burst_req;
  logic [LEN_WIDTH-1:0]  ddr_wr_burst_len;
  logic [BA-1:0]         ddr_wr_burst_addr;
  logic [DATA_WIDTH-1:0] ddr_wr_burst_data;
  logic                  ddr_wr_burst_data_req;
  logic                  ddr_wr_burst_finish;

  logic                  ddr_rd_burst_req;
  logic [LEN_WIDTH-1:0]  ddr_rd_burst_len;
  logic [BA-1:0]         ddr_rd_burst_addr;
  logic                  ddr_rd_burst_data_valid;
  logic                  ddr_rd_burst_finish;
  logic [DATA_WIDTH-1:0] ddr_rd_burst_data;

  modport master (
    output ddr_wr_burst_req, ddr_wr_burst_len, ddr_wr_burst_addr, ddr_wr_burst_data,
    input  ddr_wr_burst_data_req, ddr_wr_burst_finish,
    output ddr_rd_burst_req, ddr_rd_burst_len, ddr_rd_burst_addr,
    input  ddr_rd_burst_data_valid, ddr_rd_burst_finish, ddr_rd_burst_data
  );

  modport slave (
    input  ddr_wr_burst_req, ddr_wr_burst_len, ddr_wr_burst_addr, ddr_wr_burst_data,
    output ddr_wr_burst_data_req, ddr_wr_burst_finish,
    input  ddr_rd_burst_req, ddr_rd_burst_len, ddr_rd_burst_addr,
    output ddr_rd_burst_data_valid, ddr_rd_burst_finish, ddr_rd_burst_data
  );

endinterface

// File: rtl/ddr_burst_arbiter_rr_arbiter4.sv
// rr_arbiter4: 4-way round-robin pick starting after last_grant. With
// mask_reads_priority set, any pending read hides all writes, so rotation
// then happens within the read class only.
module rr_arbiter4 import ddr_arb_pkg::*; (
  input  logic [3:0] request,
  input  logic [1:0] last_grant,
  input  logic       mask_reads_priority,
  output logic       grant_valid,
  output logic [1:0] grant
);

  logic       rd_pending;
  logic [3:0] eligible;

  assign rd_pending = request[RD0] | request[RD1];

  // Hide writes while reads are pending and read priority is enabled.
  always_comb begin
    eligible = request;
    if (mask_reads_priority && rd_pending) begin
      eligible = request & 4'b1100;
    end
  end

  // Search last_grant+1, +2, +3, +4 (wraps mod 4) and keep the first hit.
  always_comb begin
    grant_valid = 1'b0;
    grant       = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      if (!grant_valid && eligible[last_grant + 2'(k)]) begin
        grant_valid = 1'b1;
        grant       = last_grant + 2'(k);
      end
    end
  end

endmodule

// File: rtl/ddr_burst_arbiter.sv
// ddr_burst_arbiter: shares one DDR burst controller between two write and
// two read requesters (order wr0, wr1, rd0, rd1), one burst at a time.
// Build option: define DDR_ARB_RD_PRIO_EN to give pending reads strict
// priority over writes; otherwise flat 4-way round-robin.
module ddr_burst_arbiter import ddr_arb_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                        mem_clk,
  input  logic                        sys_nrst,
  input  logic                        init_calib_complete,
  input  logic [1:0]                  wr_req,
  input  logic [2*LEN_WIDTH-1:0]      wr_len,
  input  logic [2*(ADDR_WIDTH-3)-1:0] wr_addr,
  input  logic [2*DATA_WIDTH-1:0]     wr_data,
  output logic [1:0]                  wr_data_req,
  output logic [1:0]                  wr_finish,
  input  logic [1:0]                  rd_req,
  input  logic [2*LEN_WIDTH-1:0]      rd_len,
  input  logic [2*(ADDR_WIDTH-3)-1:0] rd_addr,
  output logic [1:0]                  rd_data_valid,
  output logic [DATA_WIDTH-1:0]       rd_data,
  output logic [1:0]                  rd_finish,
  ddr_burst_arbiter_if.master         ddr,
  output logic                        busy,
  output logic [1:0]                  grant_id
);

  localparam int BA = ADDR_WIDTH - 3;
`ifdef DDR_ARB_RD_PRIO_EN
  localparam logic RD_PRIO = 1'b1;
`else
  localparam logic RD_PRIO = 1'b0;
`endif

  logic [1:0]           rst_sync;
  logic                 rst_n;
  arb_state_t           state;
  logic [1:0]           last_grant;
  logic [3:0]           request;
  logic                 arb_valid;
  logic [1:0]           arb_grant;
  logic [LEN_WIDTH-1:0] sel_len;
  logic [BA-1:0]        sel_addr;
  logic                 finish_hit;
  logic                 in_busy;

  // Reset asserts at once, releases two clocks after sys_nrst rises.
  always_ff @(posedge mem_clk or negedge sys_nrst) begin
    if (!sys_nrst) rst_sync <= 2'b00;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign request[WR0] = wr_req[0];
  assign request[WR1] = wr_req[1];
  assign request[RD0] = rd_req[0];
  assign request[RD1] = rd_req[1];

  rr_arbiter4 u_rr (
    .request             (request),
    .last_grant          (last_grant),
    .mask_reads_priority (RD_PRIO),
    .grant_valid         (arb_valid),
    .grant               (arb_grant)
  );

  // Length/address of the candidate requester, latched on grant.
  always_comb begin
    if (arb_grant[1]) begin
      sel_len  = arb_grant[0] ? rd_len[2*LEN_WIDTH-1:LEN_WIDTH] : rd_len[LEN_WIDTH-1:0];
      sel_addr = arb_grant[0] ? rd_addr[2*BA-1:BA] : rd_addr[BA-1:0];
    end else begin
      sel_len  = arb_grant[0] ? wr_len[2*LEN_WIDTH-1:LEN_WIDTH] : wr_len[LEN_WIDTH-1:0];
      sel_addr = arb_grant[0] ? wr_addr[2*BA-1:BA] : wr_addr[BA-1:0];
    end
  end

  // Only the finish of the direction in flight ends a burst.
  assign finish_hit = grant_id[1] ? ddr.ddr_rd_burst_finish : ddr.ddr_wr_burst_finish;
  assign in_busy    = (state == ST_BUSY);

  // Arbiter FSM with registered grant and DDR command outputs.
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= ST_IDLE;
      last_grant            <= RD1;
      grant_id              <= 2'd0;
      busy                  <= 1'b0;
      ddr.ddr_wr_burst_req  <= 1'b0;
      ddr.ddr_wr_burst_len  <= '0;
      ddr.ddr_wr_burst_addr <= '0;
      ddr.ddr_rd_burst_req  <= 1'b0;
      ddr.ddr_rd_burst_len  <= '0;
      ddr.ddr_rd_burst_addr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (init_calib_complete && arb_valid) begin
            state      <= ST_BUSY;
            busy       <= 1'b1;
            grant_id   <= arb_grant;
            last_grant <= arb_grant;
            if (arb_grant[1]) begin
              ddr.ddr_rd_burst_req  <= 1'b1;
              ddr.ddr_rd_burst_len  <= sel_len;
              ddr.ddr_rd_burst_addr <= sel_addr;
            end else begin
              ddr.ddr_wr_burst_req  <= 1'b1;
              ddr.ddr_wr_burst_len  <= sel_len;
              ddr.ddr_wr_burst_addr <= sel_addr;
            end
          end
        end
        ST_BUSY: begin
          if (finish_hit) begin
            state                <= ST_GAP;
            busy                 <= 1'b0;
            ddr.ddr_wr_burst_req <= 1'b0;
            ddr.ddr_rd_burst_req <= 1'b0;
          end
        end
        // One dead cycle lets the finished requester drop its request.
        ST_GAP:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Write data follows the granted write port; read data goes to both.
  assign ddr.ddr_wr_burst_data = grant_id[0] ? wr_data[2*DATA_WIDTH-1:DATA_WIDTH]
                                             : wr_data[DATA_WIDTH-1:0];
  assign rd_data = ddr.ddr_rd_burst_data;

  // Route per-beat strobes and finish only to the granted port.
  for (genvar gi = 0; gi < 2; gi++) begin : g_route
    logic sel_wr;
    logic sel_rd;
    assign sel_wr = in_busy && !grant_id[1] && (grant_id[0] == 1'(gi));
    assign sel_rd = in_busy &&  grant_id[1] && (grant_id[0] == 1'(gi));
    assign wr_data_req[gi]   = sel_wr & ddr.ddr_wr_burst_data_req;
    assign wr_finish[gi]     = sel_wr & ddr.ddr_wr_burst_finish;
    assign rd_data_valid[gi] = sel_rd & ddr.ddr_rd_burst_data_valid;
    assign rd_finish[gi]     = sel_rd & ddr.ddr_rd_burst_finish;
  end

endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// tb_ddr_burst_arbiter: directed bench; the bench plays both the requesters
// and the DDR burst controller. Honours DDR_ARB_RD_PRIO_EN for the
// arbitration-order scenario.
module tb_ddr_burst_arbiter;
  import ddr_arb_pkg::*;

  localparam int DW = 256;
  localparam int AW = 28;
  localparam int LW = 10;
  localparam int BA = AW - 3;

  logic          mem_clk = 1'b0;
  logic          sys_nrst;
  logic          calib;
  logic [1:0]    wr_req, rd_req;
  logic [LW-1:0] wl [2];
  logic [LW-1:0] rl [2];
  logic [BA-1:0] wa [2];
  logic [BA-1:0] ra [2];
  logic [DW-1:0] wd [2];

  logic [2*LW-1:0] wr_len, rd_len;
  logic [2*BA-1:0] wr_addr, rd_addr;
  logic [2*DW-1:0] wr_data;
  logic [1:0]      wr_data_req, wr_finish, rd_data_valid, rd_finish, grant_id;
  logic [DW-1:0]   rd_data;
  logic            busy;

  int checks = 0;
  int errors = 0;

  assign wr_len  = {wl[1], wl[0]};
  assign rd_len  = {rl[1], rl[0]};
  assign wr_addr = {wa[1], wa[0]};
  assign rd_addr = {ra[1], ra[0]};
  assign wr_data = {wd[1], wd[0]};

  ddr_burst_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dif ();

  ddr_burst_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .mem_clk             (mem_clk),
    .sys_nrst            (sys_nrst),
    .init_calib_complete (calib),
    .wr_req              (wr_req),
    .wr_len              (wr_len),
    .wr_addr             (wr_addr),
    .wr_data             (wr_data),
    .wr_data_req         (wr_data_req),
    .wr_finish           (wr_finish),
    .rd_req              (rd_req),
    .rd_len              (rd_len),
    .rd_addr             (rd_addr),
    .rd_data_valid       (rd_data_valid),
    .rd_data             (rd_data),
    .rd_finish           (rd_finish),
    .ddr                 (dif),
    .busy                (busy),
    .grant_id            (grant_id)
  );

  always #5 mem_clk = ~mem_clk;

  // Safety net against a hung run.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge mem_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_nrst = 1'b0;
    cyc(); cyc();
    sys_nrst = 1'b1;
    repeat (4) cyc();
  endtask

  // Wait for a grant, check it, run 'beats' beats and finish like a DDR controller.
  task automatic serve(input string tag, input logic [1:0] exp_gid, input int beats, output int waited);
    int         hits;
    logic [1:0] pm;
    pm     = exp_gid[0] ? 2'b10 : 2'b01;
    waited = 0;
    while (!(dif.ddr_wr_burst_req || dif.ddr_rd_burst_req) && waited < 40) begin
      cyc();
      waited++;
    end
    chk({tag, "_timeout"}, 256'(waited < 40), 256'(1));
    chk({tag, "_grant"}, 256'(grant_id), 256'(exp_gid));
    chk({tag, "_mutex"}, 256'(dif.ddr_wr_burst_req & dif.ddr_rd_burst_req), 256'(0));
    chk({tag, "_busy"}, 256'(busy), 256'(1));
    if (exp_gid[1]) begin
      chk({tag, "_rlen"}, 256'(dif.ddr_rd_burst_len), 256'(rl[exp_gid[0]]));
      chk({tag, "_raddr"}, 256'(dif.ddr_rd_burst_addr), 256'(ra[exp_gid[0]]));
    end else begin
      chk({tag, "_wlen"}, 256'(dif.ddr_wr_burst_len), 256'(wl[exp_gid[0]]));
      chk({tag, "_waddr"}, 256'(dif.ddr_wr_burst_addr), 256'(wa[exp_gid[0]]));
    end
    hits = 0;
    for (int b = 0; b < beats; b++) begin
      if (dif.ddr_rd_burst_req) dif.ddr_rd_burst_data_valid = 1'b1;
      else                      dif.ddr_wr_burst_data_req   = 1'b1;
      #1;
      if (exp_gid[1])
        hits += (rd_data_valid === pm && wr_data_req === 2'b00 &&
                 rd_data === dif.ddr_rd_burst_data) ? 1 : 0;
      else
        hits += (wr_data_req === pm && rd_data_valid === 2'b00 &&
                 dif.ddr_wr_burst_data === wd[exp_gid[0]]) ? 1 : 0;
      cyc();
    end
    dif.ddr_rd_burst_data_valid = 1'b0;
    dif.ddr_wr_burst_data_req   = 1'b0;
    chk({tag, "_beats"}, 256'(hits), 256'(beats));
    if (dif.ddr_rd_burst_req) dif.ddr_rd_burst_finish = 1'b1;
    else                      dif.ddr_wr_burst_finish = 1'b1;
    #1;
    chk({tag, "_finish"}, 256'({rd_finish, wr_finish}),
        256'(exp_gid[1] ? {pm, 2'b00} : {2'b00, pm}));
    cyc();
    dif.ddr_rd_burst_finish = 1'b0;
    dif.ddr_wr_burst_finish = 1'b0;
    // Now in GAP: command and busy already low.
    chk({tag, "_after"}, 256'({dif.ddr_wr_burst_req, dif.ddr_rd_burst_req, busy}), 256'(0));
  endtask

  initial begin
    int         w;
    logic [1:0] order [5];

    sys_nrst = 1'b0;
    calib    = 1'b1;
    wr_req   = 2'b00;
    rd_req   = 2'b00;
    for (int i = 0; i < 2; i++) begin
      wl[i] = '0; rl[i] = '0; wa[i] = '0; ra[i] = '0;
    end
    wd[0] = {8{32'h1111_0000}};
    wd[1] = {8{32'h2222_0001}};
    dif.ddr_wr_burst_data_req   = 1'b0;
    dif.ddr_wr_burst_finish     = 1'b0;
    dif.ddr_rd_burst_data_valid = 1'b0;
    dif.ddr_rd_burst_finish     = 1'b0;
    dif.ddr_rd_burst_data       = {8{32'hCAFE_F00D}};

    // Reset state: nothing granted even with a request and controller strobes.
    wr_req = 2'b01;
    dif.ddr_wr_burst_data_req = 1'b1;
    cyc(); cyc();
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_grant_id", 256'(grant_id), 256'(0));
    chk("rst_ddr_req", 256'({dif.ddr_wr_burst_req, dif.ddr_rd_burst_req}), 256'(0));
    chk("rst_strobes", 256'({wr_data_req, rd_data_valid, wr_finish, rd_finish}), 256'(0));
    dif.ddr_wr_burst_data_req = 1'b0;
    wr_req   = 2'b00;
    sys_nrst = 1'b1;
    repeat (4) cyc();

    // wr0 burst, len 16 at 0x100: command 1 cycle after request.
    wl[0]  = 10'd16;
    wa[0]  = 25'h100;
    wr_req = 2'b01;
    #1;
    chk("s1_req_early", 256'(dif.ddr_wr_burst_req), 256'(0));
    serve("s1", WR0, 16, w);
    chk("s1_latency", 256'(w), 256'(1));
    wr_req = 2'b00;
    cyc(); cyc();
    chk("s1_no_regrant", 256'({dif.ddr_wr_burst_req, busy}), 256'(0));

    // Spurious finish in IDLE: no pulse and FSM still grants in 1 cycle.
    dif.ddr_wr_burst_finish = 1'b1;
    dif.ddr_rd_burst_finish = 1'b1;
    #1;
    chk("sp_finish", 256'({wr_finish, rd_finish}), 256'(0));
    chk("sp_busy", 256'(busy), 256'(0));
    cyc();
    dif.ddr_wr_burst_finish = 1'b0;
    dif.ddr_rd_burst_finish = 1'b0;
    wl[1]  = 10'd20;
    wa[1]  = 25'h1234;
    wr_req = 2'b10;
    serve("sp", WR1, 3, w);
    chk("sp_latency", 256'(w), 256'(1));
    wr_req = 2'b00;
    cyc(); cyc();

    // rd1 held off by calibration, then granted 1 cycle after calib rises.
    calib  = 1'b0;
    rl[1]  = 10'd8;
    ra[1]  = 25'h2A0;
    rd_req = 2'b10;
    repeat (3) cyc();
    chk("cal_no_grant", 256'({dif.ddr_rd_burst_req, busy}), 256'(0));
    calib = 1'b1;
    #1;
    chk("cal_req_early", 256'(dif.ddr_rd_burst_req), 256'(0));
    cyc();
    chk("cal_req_rise", 256'(dif.ddr_rd_burst_req), 256'(1));
    // Calibration drops mid-burst: burst completes, next grant waits.
    calib  = 1'b0;
    wl[0]  = 10'd4;
    wa[0]  = 25'h40;
    wr_req = 2'b01;
    serve("cal", RD1, 4, w);
    rd_req = 2'b00;
    repeat (3) cyc();
    chk("cal_hold", 256'({dif.ddr_wr_burst_req, busy}), 256'(0));
    calib = 1'b1;
    serve("cal_wr", WR0, 2, w);
    chk("cal_wr_latency", 256'(w), 256'(1));
    wr_req = 2'b00;
    cyc(); cyc();

    // All four requesting continuously, from a fresh reset (last_grant = rd1).
    do_reset();
    wl[0] = 10'd5;  wa[0] = 25'h10;
    wl[1] = 10'd6;  wa[1] = 25'h20;
    rl[0] = 10'd7;  ra[0] = 25'h30;
    rl[1] = 10'd9;  ra[1] = 25'h50;
`ifdef DDR_ARB_RD_PRIO_EN
    order[0] = RD0; order[1] = RD1; order[2] = RD0; order[3] = RD1; order[4] = WR0;
`else
    order[0] = WR0; order[1] = WR1; order[2] = RD0; order[3] = RD1; order[4] = WR0;
`endif
    wr_req = 2'b11;
    rd_req = 2'b11;
    for (int i = 0; i < 5; i++) begin
`ifdef DDR_ARB_RD_PRIO_EN
      if (i == 4) rd_req = 2'b00;
`endif
      serve($sformatf("rr%0d", i), order[i], 2, w);
      // Between bursts: one GAP cycle plus the IDLE sampling cycle.
      chk($sformatf("rr%0d_gap", i), 256'(w), 256'((i == 0) ? 1 : 2));
    end
    wr_req = 2'b00;
    rd_req = 2'b00;
    repeat (3) cyc();

    // Reset at beat 5 of a 32-beat write: outputs drop at once.
    wl[0]  = 10'd32;
    wa[0]  = 25'h300;
    wr_req = 2'b01;
    cyc();
    chk("mr_req", 256'(dif.ddr_wr_burst_req), 256'(1));
    dif.ddr_wr_burst_data_req = 1'b1;
    repeat (4) cyc();
    chk("mr_beat5", 256'(wr_data_req), 256'(2'b01));
    sys_nrst = 1'b0;
    #1;
    chk("mr_outputs", 256'({dif.ddr_wr_burst_req, dif.ddr_rd_burst_req, busy, wr_data_req, wr_finish}), 256'(0));
    chk("mr_grant_id", 256'(grant_id), 256'(0));
    dif.ddr_wr_burst_data_req = 1'b0;
    wr_req = 2'b11;
    cyc();
    chk("mr_held", 256'({dif.ddr_wr_burst_req, busy}), 256'(0));
    sys_nrst = 1'b1;
    // Two synchronizer clocks, then the first arbitration edge.
    serve("mr_resume", WR0, 2, w);
    chk("mr_release_latency", 256'(w), 256'(3));
    serve("mr_next", WR1, 2, w);
    chk("mr_next_gap", 256'(w), 256'(2));
    wr_req = 2'b00;
    repeat (3) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr_burst_arbiter.md
DDR_BURST_ARBITER -- requirements
Module: ddr_burst_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 256, which sets the burst data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 28, which sets the DDR app address width; burst address width is ADDR_WIDTH-3.
REQ-003 SHALL have parameter LEN_WIDTH, default 10, which sets the burst length width.
REQ-004 SHALL have one clock and an asynchronous active-low reset.
REQ-005 SHALL have the following ports; port i is 0..1 and vectors are packed port-major.
- mem_clk  in  1  sole clock (DDR user clock)
- sys_nrst  in  1  asynchronous active-low reset
- init_calib_complete  in  1  DDR ready
- wr_req  in  2  per-port write burst request, level
- wr_len  in  2*LEN_WIDTH  write lengths
- wr_addr  in  2*(ADDR_WIDTH-3)  write addresses
- wr_data  in  2*DATA_WIDTH  write data
- wr_data_req  out  2  write data request, routed
- wr_finish  out  2  write done pulse, routed
- rd_req  in  2  per-port read burst request, level
- rd_len  in  2*LEN_WIDTH  read lengths
- rd_addr  in  2*(ADDR_WIDTH-3)  read addresses
- rd_data_valid  out  2  read data valid, routed
- rd_data  out  DATA_WIDTH  read data, broadcast to both ports
- rd_finish  out  2  read done pulse, routed
- ddr_wr_burst_req/len/addr/data  out  1/LEN/ADDR-3/DATA  to DDR controller
- ddr_wr_burst_data_req, ddr_wr_burst_finish  in  1  from DDR controller
- ddr_rd_burst_req/len/addr  out  1/LEN/ADDR-3  to DDR controller
- ddr_rd_burst_data_valid, ddr_rd_burst_finish  in  1; ddr_rd_burst_data  in  DATA_WIDTH
- busy  out  1  a burst is granted
- grant_id  out  2  {is_read, port}, valid while busy

Function
REQ-006 SHALL implement the FSM IDLE -> BUSY -> GAP -> IDLE.
REQ-007 IDLE SHALL grant only when init_calib_complete=1 and any request is high.
REQ-008 The grant SHALL be registered, so the selected ddr_*_burst_req rises exactly 1 cycle after the request is sampled.
REQ-009 Requester order for arbitration SHALL be 0=wr0, 1=wr1, 2=rd0, 3=rd1.
REQ-010 Arbitration SHALL be round-robin, with the search starting at last_grant+1 mod 4; last_grant resets to 3.
REQ-011 len and addr SHALL be latched at grant and held constant on the DDR outputs through BUSY.
REQ-012 ddr_wr_burst_data SHALL be a combinational mux of the granted write port.
REQ-013 In BUSY, only the granted port SHALL receive wr_data_req, rd_data_valid and finish; all other ports SHALL see 0.
REQ-014 On ddr_*_burst_finish, the arbiter SHALL forward the finish pulse the same cycle, clear ddr_*_burst_req from the next cycle, and enter GAP.
REQ-015 GAP SHALL last exactly 1 cycle so the finished requester can drop its request before re-arbitration.
REQ-016 A request that drops while not granted SHALL be ignored; requests are not queued.
REQ-017 ddr_wr_burst_req and ddr_rd_burst_req SHALL never be high together.
REQ-018 A finish pulse arriving in IDLE or GAP SHALL be ignored.
REQ-019 If init_calib_complete falls during BUSY, the burst SHALL complete normally and no new grant SHALL follow until it returns high.

Reset
REQ-020 Assertion of sys_nrst SHALL immediately force the FSM to IDLE, last_grant to 3 and grant_id to 0.
REQ-021 During reset, all req, finish, data_req, data_valid and busy outputs SHALL be 0.
REQ-022 A burst in flight during reset SHALL be abandoned.
REQ-023 Reset SHALL deassert synchronously through a two-flop synchronizer.

Configuration
REQ-024 Macro DDR_ARB_RD_PRIO_EN, when defined, SHALL give any pending read strict priority over all writes, with round-robin applied only within each class.
REQ-025 Without DDR_ARB_RD_PRIO_EN, the arbiter SHALL use flat 4-way round-robin.

Structure
REQ-026 The shared package ddr_arb_pkg SHALL hold the FSM state enum, the requester-index constants (WR0, WR1, RD0, RD1) and the default width constants.
REQ-027 The arbitration logic SHALL be one sub-module, rr_arbiter4, with request[3:0], last_grant and mask-reads-priority inputs and a grant index output.

Verification
REQ-028 Verification SHALL cover these scenarios:
- wr0 requests with len=16 and addr=0x100 -> ddr_wr_burst_req rises 1 cycle later with len=16 and addr=0x100; 16 wr_data_req[0] pulses; wr_finish[0] pulse; req low on the next cycle.
- All four requesting continuously with flat round-robin -> grant order wr0, wr1, rd0, rd1, wr0, with exactly 1 GAP cycle between bursts.
- Same as above with DDR_ARB_RD_PRIO_EN -> grant order rd0, rd1, rd0, rd1; writes start only after reads stop.
- rd1 requests while init_calib_complete=0 -> no grant; ddr_rd_burst_req rises 1 cycle after calib goes high.
- sys_nrst asserted mid-burst at beat 5 of 32 -> outputs go 0 immediately; after release, grant_id=0 and arbitration resumes from wr0.
- A spurious ddr_wr_burst_finish in IDLE -> no wr_finish pulse on any port and the FSM remains in IDLE.
